// File: rtl/spi_pkg.sv
// Shared encodings for the parameterised SPI master: FSM states, SPI mode
// constants and helpers that pull CPOL/CPHA out of a 2-bit mode word.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_XFER  = 2'd2,
    ST_TRAIL = 2'd3
  } spi_state_e;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  localparam int CPOL_BIT = 1;
  localparam int CPHA_BIT = 0;

  function automatic logic cpol(input logic [1:0] m);
    return m[CPOL_BIT];
  endfunction

  function automatic logic cpha(input logic [1:0] m);
    return m[CPHA_BIT];
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period divider and SCK edge indexer. edge_cnt_o is the index of the
// edge that fires on the current tick; index 2*DATA_W+1 marks end of XFER.
module spi_clk_gen #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 2,
  parameter int EW      = $clog2(2*DATA_W+3)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run_i,
  input  logic          clear_i,
  input  logic          cpha_i,
  output logic          tick_o,
  output logic [EW-1:0] edge_cnt_o,
  output logic          sample_en_o,
  output logic          shift_en_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] div_q;
  logic [EW-1:0] hp_q;
  logic          edge_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q <= '0;
      hp_q  <= '0;
    end else if (clear_i) begin
      div_q <= '0;
      hp_q  <= '0;
    end else if (run_i) begin
      if (tick_o) begin
        div_q <= '0;
        hp_q  <= hp_q + EW'(1);
      end else begin
        div_q <= div_q + CW'(1);
      end
    end
  end

  assign tick_o     = run_i && (div_q == CW'(CLK_DIV-1));
  assign edge_cnt_o = hp_q + EW'(1);
  // The tick closing the last XFER half-period carries no SCK edge.
  assign edge_ok     = tick_o && (edge_cnt_o <= EW'(2*DATA_W));
  assign sample_en_o = edge_ok && (edge_cnt_o[0] != cpha_i);
  assign shift_en_o  = edge_ok && (edge_cnt_o[0] == cpha_i);

endmodule

// File: rtl/spi_master_param.sv
// Parameterised SPI master: runtime CPOL/CPHA, MSB/LSB order, decoded
// active-low selects with optional hold between words. Outputs registered.
module spi_master_param
  import spi_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int CLK_DIV   = 2,
  parameter int N_SS      = 4,
  parameter int MSB_FIRST = 1,
  localparam int SEL_W    = (N_SS > 1) ? $clog2(N_SS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  input  logic [SEL_W-1:0]  ss_sel,
  input  logic [1:0]        mode,
  input  logic              hold_ss,
  input  logic              miso,
  output logic              mosi,
  output logic              sck,
  output logic [N_SS-1:0]   ss_n,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              new_data
);

  localparam int EW = $clog2(2*DATA_W+3);

  spi_state_e        state_q, state_d;
  logic              sck_q, sck_d, mosi_q, mosi_d;
  logic [N_SS-1:0]   ss_n_q, ss_n_d;
  logic [DATA_W-1:0] tx_q, tx_d, rx_q, rx_d, dout_q, dout_d;
  logic              busy_q, busy_d, nd_q, nd_d, hold_q, hold_d;
  logic [1:0]        mode_q, mode_d;
  logic              clear, tick, sample_en, shift_en;
  logic [EW-1:0]     edge_cnt;

  function automatic logic head(input logic [DATA_W-1:0] w);
    return (MSB_FIRST != 0) ? w[DATA_W-1] : w[0];
  endfunction

  // Shift one bit in from the far end; same direction for TX and RX.
  function automatic logic [DATA_W-1:0] shin(input logic [DATA_W-1:0] w, input logic b);
    return (MSB_FIRST != 0) ? {w[DATA_W-2:0], b} : {b, w[DATA_W-1:1]};
  endfunction

  spi_clk_gen #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV), .EW(EW)) u_clk_gen (
    .clk         (clk),
    .rst         (rst),
    .run_i       (state_q != ST_IDLE),
    .clear_i     (clear),
    .cpha_i      (cpha(mode_q)),
    .tick_o      (tick),
    .edge_cnt_o  (edge_cnt),
    .sample_en_o (sample_en),
    .shift_en_o  (shift_en)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    ss_n_d  = ss_n_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    dout_d  = dout_q;
    busy_d  = busy_q;
    mode_d  = mode_q;
    hold_d  = hold_q;
    nd_d    = 1'b0;
    clear   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        sck_d = cpol(mode_q);
        if (!hold_ss) ss_n_d = '1;
        if (start) begin
          clear   = 1'b1;
          mode_d  = mode;
          hold_d  = hold_ss;
          busy_d  = 1'b1;
          sck_d   = cpol(mode);
          ss_n_d  = ~(N_SS'(1) << ss_sel);
          rx_d    = '0;
          state_d = ST_SETUP;
          // CPHA=0 slaves sample on edge 1, so the first bit goes out now.
          if (!cpha(mode)) begin
            mosi_d = head(data_in);
            tx_d   = shin(data_in, 1'b1);
          end else begin
            tx_d   = data_in;
          end
        end
      end
      ST_SETUP: if (tick) state_d = ST_XFER;
      ST_XFER:  if (tick && edge_cnt == EW'(2*DATA_W+1)) state_d = ST_TRAIL;
      ST_TRAIL: begin
        if (tick) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          nd_d    = 1'b1;
          dout_d  = rx_q;
          if (!(hold_q && hold_ss)) ss_n_d = '1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (sample_en || shift_en) sck_d = ~sck_q;
    if (sample_en) rx_d = shin(rx_q, miso);
    if (shift_en) begin
      mosi_d = head(tx_q);
      tx_d   = shin(tx_q, 1'b1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sck_q  <= 1'b0;
      mosi_q <= 1'b1;
      ss_n_q <= '1;
      tx_q   <= '0;
      rx_q   <= '0;
      dout_q <= '0;
      busy_q <= 1'b0;
      nd_q   <= 1'b0;
      mode_q <= MODE0;
      hold_q <= 1'b0;
    end else begin
      sck_q  <= sck_d;
      mosi_q <= mosi_d;
      ss_n_q <= ss_n_d;
      tx_q   <= tx_d;
      rx_q   <= rx_d;
      dout_q <= dout_d;
      busy_q <= busy_d;
      nd_q   <= nd_d;
      mode_q <= mode_d;
      hold_q <= hold_d;
    end
  end

  assign sck      = sck_q;
  assign mosi     = mosi_q;
  assign ss_n     = ss_n_q;
  assign data_out = dout_q;
  assign busy     = busy_q;
  assign new_data = nd_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Scoreboard bench: two master configurations, each with a behavioural SPI
// slave; the driver queues expected words, a monitor checks on new_data.
module tb_spi_master_param;
  import spi_pkg::*;

  typedef struct {
    logic [15:0] tx;
    logic [15:0] rx;
    int          sel;
    logic [1:0]  mode;
    bit          hold;
  } xfer_t;

  typedef struct {
    xfer_t       cur;
    int          ecnt;
    int          sh;
    int          ncap;
    logic [15:0] cap;
    logic        sck_p;
    logic        busy_p;
    logic        miso;
    int          bcyc;
    int          ss_bad;
  } slv_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic       a_start, a_hold, a_miso, a_mosi, a_sck, a_busy, a_nd;
  logic [7:0] a_din, a_dout;
  logic [1:0] a_sel, a_mode;
  logic [3:0] a_ssn;

  logic        b_start, b_hold, b_miso, b_mosi, b_sck, b_busy, b_nd;
  logic [15:0] b_din, b_dout;
  logic [0:0]  b_sel;
  logic [1:0]  b_mode, b_ssn;

  spi_master_param #(.DATA_W(8), .CLK_DIV(2), .N_SS(4), .MSB_FIRST(1)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .data_in(a_din), .ss_sel(a_sel),
    .mode(a_mode), .hold_ss(a_hold), .miso(a_miso), .mosi(a_mosi), .sck(a_sck),
    .ss_n(a_ssn), .data_out(a_dout), .busy(a_busy), .new_data(a_nd));

  spi_master_param #(.DATA_W(16), .CLK_DIV(1), .N_SS(2), .MSB_FIRST(0)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .data_in(b_din), .ss_sel(b_sel),
    .mode(b_mode), .hold_ss(b_hold), .miso(b_miso), .mosi(b_mosi), .sck(b_sck),
    .ss_n(b_ssn), .data_out(b_dout), .busy(b_busy), .new_data(b_nd));

  int    checks = 0, fails = 0;
  int    ndA = 0, ndB = 0, expA = 0, expB = 0;
  xfer_t sbA[$], sbB[$];
  slv_t  sa, sb;
  xfer_t xz = '{tx: 16'h0, rx: 16'h0, sel: 0, mode: 2'b00, hold: 1'b0};

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Bit i of a word in transmission order; past the end the line idles high.
  function automatic logic bitof(input logic [15:0] w, input int i, input int dw, input bit msb);
    if (i < 0 || i >= dw) return 1'b1;
    return msb ? w[dw-1-i] : w[i];
  endfunction

  task automatic slave_step(inout slv_t s, input logic rstn, input logic busy, input logic sck,
                            input logic mosi, input logic [3:0] ssn, input int dw, input bit msb,
                            input xfer_t front);
    if (!rstn) begin
      s.busy_p = 1'b0;
      s.miso   = 1'b1;
      s.bcyc   = 0;
      return;
    end
    if (busy && !s.busy_p) begin
      s.cur  = front;
      s.ecnt = 0;
      s.sh   = 0;
      s.ncap = 0;
      s.cap  = '0;
      s.miso = s.cur.mode[0] ? 1'b1 : bitof(s.cur.rx, 0, dw, msb);
    end else if (busy && sck !== s.sck_p) begin
      s.ecnt++;
      if ((s.ecnt % 2 == 1) == (s.cur.mode[0] == 1'b0)) begin
        if (s.ncap < dw) s.cap[msb ? dw-1-s.ncap : s.ncap] = mosi;
        s.ncap++;
      end else begin
        s.sh++;
        s.miso = bitof(s.cur.rx, s.cur.mode[0] ? s.sh-1 : s.sh, dw, msb);
      end
    end
    if (busy) begin
      s.bcyc++;
      if (ssn !== ~(4'b0001 << s.cur.sel)) s.ss_bad++;
    end
    if ($countones(~ssn) > 1) s.ss_bad++;
    s.sck_p  = sck;
    s.busy_p = busy;
  endtask

  task automatic check_done(input string t, input slv_t s, input xfer_t e, input logic [15:0] dout,
                            input logic sck, input logic busy, input logic [3:0] ssn,
                            input int dw, input int cd);
    logic [3:0] ssx;
    ssx = e.hold ? ~(4'b0001 << e.sel) : 4'hF;
    chk({t, " data_out"}, 32'(dout), 32'(e.rx));
    chk({t, " mosi word"}, 32'(s.cap), 32'(e.tx));
    chk({t, " mosi bits seen"}, s.ncap, dw);
    chk({t, " busy at new_data"}, 32'(busy), 32'(0));
    chk({t, " busy cycles"}, s.bcyc, (2*dw+2)*cd);
    chk({t, " idle sck"}, 32'(sck), 32'(e.mode[1]));
    chk({t, " ss_n at new_data"}, 32'(ssn), 32'(ssx));
    chk({t, " ss_n violations"}, s.ss_bad, 0);
  endtask

  initial forever begin : mon_a
    xfer_t f, e;
    @(negedge clk);
    if (sbA.size() > 0) f = sbA[0]; else f = xz;
    slave_step(sa, rst, a_busy, a_sck, a_mosi, a_ssn, 8, 1'b1, f);
    a_miso = sa.miso;
    if (rst && a_nd) begin
      ndA++;
      if (sbA.size() == 0) begin
        checks++; fails++;
        $display("FAIL A new_data with nothing pending: got pulse expected none");
      end else begin
        e = sbA.pop_front();
        check_done("A", sa, e, 16'(a_dout), a_sck, a_busy, a_ssn, 8, 2);
      end
      sa.bcyc = 0;
      sa.ss_bad = 0;
    end
  end

  initial forever begin : mon_b
    xfer_t f, e;
    @(negedge clk);
    if (sbB.size() > 0) f = sbB[0]; else f = xz;
    slave_step(sb, rst, b_busy, b_sck, b_mosi, {2'b11, b_ssn}, 16, 1'b0, f);
    b_miso = sb.miso;
    if (rst && b_nd) begin
      ndB++;
      if (sbB.size() == 0) begin
        checks++; fails++;
        $display("FAIL B new_data with nothing pending: got pulse expected none");
      end else begin
        e = sbB.pop_front();
        check_done("B", sb, e, b_dout, b_sck, b_busy, {2'b11, b_ssn}, 16, 1);
      end
      sb.bcyc = 0;
      sb.ss_bad = 0;
    end
  end

  // Called at a negedge while the DUT is idle (or in its new_data cycle).
  task automatic a_go(input logic [7:0] d, input logic [7:0] r, input int sel,
                      input logic [1:0] md, input bit hold);
    xfer_t e;
    e = '{tx: 16'(d), rx: 16'(r), sel: sel, mode: md, hold: hold};
    a_din = d; a_sel = 2'(sel); a_mode = md; a_hold = hold; a_start = 1'b1;
    sbA.push_back(e);
    expA++;
    @(negedge clk);
    a_start = 1'b0;
    a_din = 8'($urandom);
  endtask

  task automatic b_go(input logic [15:0] d, input logic [15:0] r, input int sel,
                      input logic [1:0] md, input bit hold);
    xfer_t e;
    e = '{tx: d, rx: r, sel: sel, mode: md, hold: hold};
    b_din = d; b_sel = 1'(sel); b_mode = md; b_hold = hold; b_start = 1'b1;
    sbB.push_back(e);
    expB++;
    @(negedge clk);
    b_start = 1'b0;
    b_din = 16'($urandom);
  endtask

  task automatic wait_nd(input bit isb);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (isb ? b_nd : a_nd) return;
    end
    checks++; fails++;
    $display("FAIL %s wait for new_data: got timeout expected pulse", isb ? "B" : "A");
  endtask

  initial begin : drive
    int n;
    logic p;
    a_start = 0; a_din = 0; a_sel = 0; a_mode = 0; a_hold = 0;
    b_start = 0; b_din = 0; b_sel = 0; b_mode = 0; b_hold = 0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    chk("reset sck", 32'(a_sck), 32'(0));
    chk("reset mosi", 32'(a_mosi), 32'(1));
    chk("reset ss_n", 32'(a_ssn), 32'hF);
    chk("reset data_out", 32'(a_dout), 32'(0));
    chk("reset busy", 32'(a_busy), 32'(0));
    chk("reset new_data", 32'(a_nd), 32'(0));
    chk("reset B ss_n", 32'(b_ssn), 32'h3);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    a_go(8'h5C, 8'hA5, 0, MODE0, 1'b0);
    wait_nd(1'b0);
    a_go(8'h5C, 8'hA5, 0, MODE3, 1'b0);
    wait_nd(1'b0);
    @(negedge clk);
    chk("mode3 sck idles high", 32'(a_sck), 32'(1));

    // A start during a busy transfer must be dropped entirely.
    a_go(8'h5C, 8'hA5, 0, MODE0, 1'b0);
    repeat (4) @(negedge clk);
    a_din = 8'hFF; a_sel = 2'd3; a_mode = MODE3; a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    wait_nd(1'b0);

    a_go(8'h12, 8'h6E, 2, MODE2, 1'b1);
    wait_nd(1'b0);
    a_go(8'h34, 8'hC3, 2, MODE2, 1'b1);
    wait_nd(1'b0);
    chk("hold ss_n after 2nd word", 32'(a_ssn), 32'hB);
    @(negedge clk);
    chk("hold ss_n while idle", 32'(a_ssn), 32'hB);
    a_hold = 1'b0;
    @(negedge clk);
    chk("hold release", 32'(a_ssn), 32'hF);

    a_go(8'h3C, 8'h99, 1, MODE0, 1'b0);
    n = 0;
    p = a_sck;
    for (int i = 0; i < 100 && n < 5; i++) begin
      @(negedge clk);
      if (a_sck !== p) n++;
      p = a_sck;
    end
    chk("edges before reset", n, 5);
    #2 rst = 1'b0;
    sbA.delete();
    expA--;
    #1;
    chk("abort ss_n", 32'(a_ssn), 32'hF);
    chk("abort sck", 32'(a_sck), 32'(0));
    chk("abort busy", 32'(a_busy), 32'(0));
    chk("abort new_data", 32'(a_nd), 32'(0));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    a_go(8'hC9, 8'h5A, 3, MODE1, 1'b0);
    wait_nd(1'b0);

    for (int i = 0; i < 20; i++) begin
      a_go(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), 2'($urandom), 1'($urandom));
      wait_nd(1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    a_hold = 1'b0;
    repeat (3) @(negedge clk);

    b_go(16'h8001, 16'hBEEF, 1, MODE1, 1'b0);
    wait_nd(1'b1);
    for (int i = 0; i < 6; i++) begin
      b_go(16'($urandom), 16'($urandom), int'($urandom_range(0, 1)), 2'($urandom), 1'($urandom));
      wait_nd(1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    b_hold = 1'b0;
    repeat (3) @(negedge clk);

    chk("A new_data pulses", ndA, expA);
    chk("B new_data pulses", ndB, expB);
    chk("A pending left", sbA.size(), 0);
    chk("B pending left", sbB.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/spi_master_param.md
Name: spi_master_param

Overview:
Parameterised successor of the team's fixed 8-bit SPI master. It adds configurable word width, SCK divider, runtime CPOL/CPHA mode, MSB/LSB ordering, N decoded slave selects and an SS-hold option for multi-word frames. It sits between the J1 SoC peripheral bus glue and off-chip SPI devices (SD card, sensors). It is a single clock domain with no CDC; MISO is treated as synchronous to clk.

Parameters:
DATA_W, 8, bits per transfer word (>=2)
CLK_DIV, 2, clk cycles per SCK half-period (>=1)
N_SS, 4, number of active-low slave-select outputs (>=1)
MSB_FIRST, 1, 1 = MSB shifted first, 0 = LSB first

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low (asserted when 0)
start  in  1  request a transfer; accepted only in IDLE
data_in  in  DATA_W  word to transmit; latched on accept
ss_sel  in  max(1,$clog2(N_SS))  slave index; latched on accept
mode  in  2  {CPOL,CPHA}; latched on accept
hold_ss  in  1  keep the selected ss_n low while idle
miso  in  1  serial data from slave
mosi  out  1  serial data to slave
sck  out  1  SPI clock
ss_n  out  N_SS  one-hot-low slave selects
data_out  out  DATA_W  last received word
busy  out  1  transfer in progress
new_data  out  1  one-cycle pulse: data_out updated

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, sck=0, mosi=1, ss_n=all 1, data_out=0, busy=0, new_data=0, latched mode=0. All outputs are registered.
- States: IDLE -> SETUP -> XFER -> TRAIL -> IDLE. A half-period counter runs 0..CLK_DIV-1 and produces a tick on the last count.
- IDLE:
  - sck = latched CPOL.
  - On start=1, latch data_in, ss_sel, mode and hold_ss. Drive ss_n[sel]=0 and all other ss_n bits high. busy=1 from the next cycle. Go to SETUP.
  - If CPHA=0, mosi presents the first bit in the accept cycle.
- SETUP: one half-period (CLK_DIV cycles). On the tick, sck toggles (edge 1) and the state moves to XFER.
- XFER: 2*DATA_W half-periods.
  - Edge k (k = 1..2*DATA_W) occurs at the start of half-period k. No edge occurs after the final half-period.
  - Sample edges are the odd k if CPHA=0, the even k if CPHA=1. On a sample edge, miso shifts into the RX register in the same clk cycle as the sck toggle.
  - Shift edges are the other parity. On a shift edge, mosi advances to the next bit.
  - CPHA=1: the first bit is driven on edge 1.
- TRAIL: one half-period with sck at CPOL. On the tick:
  - data_out <= RX register, new_data=1 for one cycle, busy=0, state IDLE.
  - new_data and busy=0 appear in the same cycle.
- busy high time: exactly (2*DATA_W+2)*CLK_DIV cycles.
- ss release:
  - Without hold: ss_n returns all-1 in the same cycle busy falls.
  - With hold: ss_n[sel] stays low while in IDLE and hold_ss=1, and releases the cycle after hold_ss=0.
  - A new start to a different ss_sel switches the selects in the accept cycle. The old select is never asserted together with the new one.
- start while busy: ignored, with no queuing.
- start in the new_data cycle: accepted (back-to-back transfer).
- Reset mid-transfer: immediate abort to the reset values. No new_data pulse is generated.
- Bit order: MSB_FIRST selects the shift direction for both TX and RX.

Decomposition:
- Package spi_pkg holds:
  - state encodings (IDLE/SETUP/XFER/TRAIL)
  - mode constants MODE0..MODE3
  - bit index helpers for CPOL/CPHA
- Sub-module spi_clk_gen holds the half-period counter and tick/edge-index generation. It outputs tick, edge_cnt, sample_en and shift_en, which the master FSM consumes.

Test Plan:
- Mode0, DATA_W=8, CLK_DIV=2, data_in=0x5C, slave returns 0xA5 -> mosi sampled on rising sck = 0,1,0,1,1,1,0,0; data_out=0xA5; new_data 36 cycles after accept; ss_n=4'b1110 (sel 0) throughout.
- Mode3 (CPOL=1,CPHA=1), same data -> sck idles high; bits valid on rising edge; data_out=0xA5; sck high after busy falls.
- start pulsed at cycle 5 of a busy transfer with data 0xFF -> ignored; mosi stream and data_out unchanged; exactly one new_data pulse.
- hold_ss=1, sel=2, two back-to-back starts (0x12, 0x34) issued in the new_data cycle -> ss_n[2] stays low across both words; release one cycle after hold_ss=0; two new_data pulses.
- rst=0 at edge 5 -> immediate ss_n=all 1, sck=0, busy=0, no new_data; next transfer completes correctly.
- DATA_W=16, MSB_FIRST=0, CLK_DIV=1, mode1, data_in=0x8001 -> mosi LSB first (1,0,...,0,1); busy high 34 cycles; slave 0xBEEF -> data_out=0xBEEF.
